// File: rtl/game_pkg.sv
// game_pkg
// Shared types and helpers for the jump-game controller.
// Contents:
//   state_t        - game state machine encoding
//   LFSR_TAPS      - feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   GAP_TABLE      - deterministic spawn gap offsets, entry 0 in the low nibble
//   TYPE_TABLE     - deterministic spawn block types, entry 0 in the low nibble
//   hw()           - landing half-width of a block type
//   abs_diff()     - 10-bit unsigned absolute difference
//   gap_offset()   - table lookup into GAP_TABLE
//   block_type()   - table lookup into TYPE_TABLE
package game_pkg;

  typedef enum logic [2:0] {
    TITLE,
    IDLE,
    CHARGE,
    JUMP,
    SCROLL,
    GAMEOVER
  } state_t;

  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
  localparam logic [15:0] GAP_TABLE  = {4'd6, 4'd2, 4'd8, 4'd4};
  localparam logic [15:0] TYPE_TABLE = {4'd3, 4'd0, 4'd2, 4'd1};

  // A block of type t accepts a landing within 2 + t[1:0] units of its x.
  function automatic logic [9:0] hw(input logic [3:0] t);
    return 10'd2 + {8'd0, t[1:0]};
  endfunction

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [3:0] gap_offset(input logic [1:0] idx);
    return GAP_TABLE[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] block_type(input logic [1:0] idx);
    return TYPE_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/block_spawner.sv
// block_spawner
// Supplies the x position and type of the next block2 to be spawned.
// The outputs always show the pending spawn; asserting spawn for one
// cycle consumes it and advances to the following one.
// Configuration macro: GAME_RANDOM_EN
//   defined   - 8-bit Fibonacci LFSR seeded with SEED, x = GAP_MIN + lfsr[3:0],
//               type = {2'b00, lfsr[5:4]}
//   undefined - fixed 4-entry cycle from the package tables
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   spawn       - consume the current spawn values
//   o_x         - x of the pending block2
//   o_type      - type of the pending block2
module block_spawner
  import game_pkg::*;
#(
  parameter int unsigned GAP_MIN = 8,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn,
  output logic [9:0] o_x,
  output logic [3:0] o_type
);

  localparam logic [9:0] GAP_BASE = 10'(GAP_MIN);

  // An all-zero seed would lock the LFSR, so reject it at elaboration.
  if (SEED == 8'h00) begin : g_seed_guard
    $error("block_spawner: SEED must be nonzero");
  end

`ifdef GAME_RANDOM_EN

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // The LFSR shifts left with the XOR of the tapped bits entering bit 0,
  // and moves only when a spawn consumes the current value.
  always_comb begin
    lfsr_d = lfsr_q;
    if (spawn) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // LFSR register, restarted from the seed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The pending block is decoded straight from the current LFSR value.
  always_comb begin
    o_x    = GAP_BASE + {6'd0, lfsr_q[3:0]};
    o_type = {2'b00, lfsr_q[5:4]};
  end

`else

  logic [1:0] idx_q;
  logic [1:0] idx_d;

  // The table index wraps naturally after four spawns.
  always_comb begin
    idx_d = idx_q;
    if (spawn) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Table index register, back to the first entry on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // The pending block comes from the current table entry.
  always_comb begin
    o_x    = GAP_BASE + {6'd0, gap_offset(idx_q)};
    o_type = block_type(idx_q);
  end

`endif

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
// Jump-game controller feeding the graphics block. All game state moves
// only on i_tick cycles: title, charge, jump, landing check, scroll, game over.
// Every output is a flop and updates on the edge that samples i_tick = 1.
// Configuration macro: GAME_RANDOM_EN (selects the spawner source, see block_spawner).
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   i_tick                       - one-cycle frame pulse
//   i_btn                        - debounced button level
//   o_x_block1/2, o_en_block1/2  - block positions and visibility
//   o_type_block1/2              - block types
//   o_x_man, o_y_man             - man x and height above the block surface
//   o_squeeze_man                - charge level 0..15
//   o_title, o_gameover          - screen flags
//   o_score                      - successful landings, saturating at 255
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CHARGE_TICKS = 4,
  parameter int unsigned JUMP_STEP    = 2,
  parameter int unsigned GAP_MIN      = 8,
  parameter int unsigned X_INIT2      = 15,
  parameter logic [7:0]  SEED         = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn,
  output logic [9:0] o_x_block1,
  output logic [9:0] o_x_block2,
  output logic       o_en_block1,
  output logic       o_en_block2,
  output logic [3:0] o_type_block1,
  output logic [3:0] o_type_block2,
  output logic [9:0] o_x_man,
  output logic [9:0] o_y_man,
  output logic [3:0] o_squeeze_man,
  output logic       o_title,
  output logic       o_gameover,
  output logic [7:0] o_score
);

  localparam logic [9:0] X2_RESET    = 10'(X_INIT2);
  localparam logic [7:0] CHARGE_LAST = 8'(CHARGE_TICKS - 1);

  state_t     state_q, state_d;
  logic       btn_q, btn_d;
  logic [9:0] x_b1_q, x_b1_d, x_b2_q, x_b2_d;
  logic       en_b1_q, en_b1_d, en_b2_q, en_b2_d;
  logic [3:0] type_b1_q, type_b1_d, type_b2_q, type_b2_d;
  logic [9:0] x_man_q, x_man_d, y_man_q, y_man_d;
  logic [3:0] squeeze_q, squeeze_d;
  logic [7:0] score_q, score_d;
  logic       title_q, title_d, gameover_q, gameover_d;
  logic [7:0] charge_cnt_q, charge_cnt_d;
  logic [9:0] jump_cnt_q, jump_cnt_d, jump_dist_q, jump_dist_d;

  logic       press, last_jump, hit1, hit2, scroll_done, spawn;
  logic [9:0] land_x, spawn_x;
  logic [3:0] spawn_type;

  block_spawner #(
    .GAP_MIN (GAP_MIN),
    .SEED    (SEED)
  ) u_spawner (
    .clk    (clk),
    .rst    (rst),
    .spawn  (spawn),
    .o_x    (spawn_x),
    .o_type (spawn_type)
  );

  // Landing is judged at the position after the final step; a zero-distance
  // jump lands where it stands. Scroll finishes on the tick that brings
  // block2 to x = 0, so the swap happens in the same tick as the last move.
  assign press       = i_btn & ~btn_q;
  assign land_x      = (jump_dist_q == 10'd0) ? x_man_q : x_man_q + 10'd1;
  assign last_jump   = (jump_dist_q == 10'd0) || (jump_cnt_q == jump_dist_q - 10'd1);
  assign hit2        = abs_diff(land_x, x_b2_q) <= hw(type_b2_q);
  assign hit1        = abs_diff(land_x, x_b1_q) <= hw(type_b1_q);
  assign scroll_done = (x_b2_q <= 10'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TITLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; nothing moves outside tick cycles.
  always_comb begin
    state_d = state_q;
    if (i_tick) begin
      case (state_q)
        TITLE:    if (press) state_d = IDLE;
        IDLE:     if (press) state_d = CHARGE;
        CHARGE:   if (!i_btn) state_d = JUMP;
        JUMP:     if (last_jump) state_d = hit2 ? SCROLL : (hit1 ? IDLE : GAMEOVER);
        SCROLL:   if (scroll_done) state_d = IDLE;
        GAMEOVER: if (press) state_d = IDLE;
        default:  state_d = TITLE;
      endcase
    end
  end

  // Datapath updates per state. Release beats a squeeze increment on the
  // same tick simply because the release branch never increments.
  always_comb begin
    btn_d        = i_tick ? i_btn : btn_q;
    x_b1_d       = x_b1_q;
    x_b2_d       = x_b2_q;
    en_b1_d      = en_b1_q;
    en_b2_d      = en_b2_q;
    type_b1_d    = type_b1_q;
    type_b2_d    = type_b2_q;
    x_man_d      = x_man_q;
    y_man_d      = y_man_q;
    squeeze_d    = squeeze_q;
    score_d      = score_q;
    title_d      = title_q;
    gameover_d   = gameover_q;
    charge_cnt_d = charge_cnt_q;
    jump_cnt_d   = jump_cnt_q;
    jump_dist_d  = jump_dist_q;
    spawn        = 1'b0;
    if (i_tick) begin
      case (state_q)
        TITLE: begin
          if (press) title_d = 1'b0;
        end
        IDLE: begin
          if (press) charge_cnt_d = 8'd0;
        end
        CHARGE: begin
          if (i_btn) begin
            if (charge_cnt_q == CHARGE_LAST) begin
              charge_cnt_d = 8'd0;
              if (squeeze_q != 4'd15) squeeze_d = squeeze_q + 4'd1;
            end else begin
              charge_cnt_d = charge_cnt_q + 8'd1;
            end
          end else begin
            jump_dist_d = 10'(squeeze_q * JUMP_STEP);
            jump_cnt_d  = 10'd0;
            squeeze_d   = 4'd0;
          end
        end
        JUMP: begin
          if (jump_dist_q != 10'd0) begin
            x_man_d    = x_man_q + 10'd1;
            jump_cnt_d = jump_cnt_q + 10'd1;
            if (jump_cnt_q < (jump_dist_q >> 1)) begin
              y_man_d = y_man_q + 10'd1;
            end else if (y_man_q != 10'd0) begin
              y_man_d = y_man_q - 10'd1;
            end
          end
          if (last_jump) begin
            y_man_d = 10'd0;
            if (hit2) begin
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
              en_b1_d = 1'b0;
            end else if (!hit1) begin
              gameover_d = 1'b1;
            end
          end
        end
        SCROLL: begin
          if (x_b2_q != 10'd0) begin
            x_b2_d = x_b2_q - 10'd1;
            if (x_man_q != 10'd0) x_man_d = x_man_q - 10'd1;
          end
          if (scroll_done) begin
            x_b1_d    = 10'd0;
            type_b1_d = type_b2_q;
            en_b1_d   = 1'b1;
            x_b2_d    = spawn_x;
            type_b2_d = spawn_type;
            en_b2_d   = 1'b1;
            spawn     = 1'b1;
          end
        end
        GAMEOVER: begin
          if (press) begin
            x_b1_d       = 10'd0;
            x_b2_d       = X2_RESET;
            en_b1_d      = 1'b1;
            en_b2_d      = 1'b1;
            type_b1_d    = 4'd0;
            type_b2_d    = 4'd0;
            x_man_d      = 10'd0;
            y_man_d      = 10'd0;
            squeeze_d    = 4'd0;
            score_d      = 8'd0;
            gameover_d   = 1'b0;
            charge_cnt_d = 8'd0;
            jump_cnt_d   = 10'd0;
            jump_dist_d  = 10'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers, including the registered screen flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q        <= 1'b0;
      x_b1_q       <= 10'd0;
      x_b2_q       <= X2_RESET;
      en_b1_q      <= 1'b1;
      en_b2_q      <= 1'b1;
      type_b1_q    <= 4'd0;
      type_b2_q    <= 4'd0;
      x_man_q      <= 10'd0;
      y_man_q      <= 10'd0;
      squeeze_q    <= 4'd0;
      score_q      <= 8'd0;
      title_q      <= 1'b1;
      gameover_q   <= 1'b0;
      charge_cnt_q <= 8'd0;
      jump_cnt_q   <= 10'd0;
      jump_dist_q  <= 10'd0;
    end else begin
      btn_q        <= btn_d;
      x_b1_q       <= x_b1_d;
      x_b2_q       <= x_b2_d;
      en_b1_q      <= en_b1_d;
      en_b2_q      <= en_b2_d;
      type_b1_q    <= type_b1_d;
      type_b2_q    <= type_b2_d;
      x_man_q      <= x_man_d;
      y_man_q      <= y_man_d;
      squeeze_q    <= squeeze_d;
      score_q      <= score_d;
      title_q      <= title_d;
      gameover_q   <= gameover_d;
      charge_cnt_q <= charge_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
      jump_dist_q  <= jump_dist_d;
    end
  end

  assign o_x_block1    = x_b1_q;
  assign o_x_block2    = x_b2_q;
  assign o_en_block1   = en_b1_q;
  assign o_en_block2   = en_b2_q;
  assign o_type_block1 = type_b1_q;
  assign o_type_block2 = type_b2_q;
  assign o_x_man       = x_man_q;
  assign o_y_man       = y_man_q;
  assign o_squeeze_man = squeeze_q;
  assign o_title       = title_q;
  assign o_gameover    = gameover_q;
  assign o_score       = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl
// Scoreboard bench for game_ctrl with default parameters and the
// deterministic spawner. Each tick (or reset) pushes the expected output
// snapshot; a monitor pops one entry per DUT update and compares it.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, i_tick, i_btn;
  logic [9:0] o_x_block1, o_x_block2, o_x_man, o_y_man;
  logic       o_en_block1, o_en_block2, o_title, o_gameover;
  logic [3:0] o_type_block1, o_type_block2, o_squeeze_man;
  logic [7:0] o_score;

  typedef struct {
    int title;
    int gameover;
    int xb1;
    int xb2;
    int en1;
    int en2;
    int tb1;
    int tb2;
    int xman;
    int yman;
    int sq;
    int score;
  } snap_t;

  typedef struct {
    bit    chk;
    snap_t e;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  snap_t     exp_cur;
  int        checks = 0;
  int        errors = 0;

  game_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_tick        (i_tick),
    .i_btn         (i_btn),
    .o_x_block1    (o_x_block1),
    .o_x_block2    (o_x_block2),
    .o_en_block1   (o_en_block1),
    .o_en_block2   (o_en_block2),
    .o_type_block1 (o_type_block1),
    .o_type_block2 (o_type_block2),
    .o_x_man       (o_x_man),
    .o_y_man       (o_y_man),
    .o_squeeze_man (o_squeeze_man),
    .o_title       (o_title),
    .o_gameover    (o_gameover),
    .o_score       (o_score)
  );

  always #5 clk = ~clk;

  function automatic snap_t reset_snap();
    snap_t s;
    s.title = 1; s.gameover = 0;
    s.xb1 = 0;   s.xb2 = 15;
    s.en1 = 1;   s.en2 = 1;
    s.tb1 = 0;   s.tb2 = 0;
    s.xman = 0;  s.yman = 0;
    s.sq = 0;    s.score = 0;
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareSnap(input snap_t e);
    checkOutput("title",    int'(o_title),       e.title);
    checkOutput("gameover", int'(o_gameover),    e.gameover);
    checkOutput("x_block1", int'(o_x_block1),    e.xb1);
    checkOutput("x_block2", int'(o_x_block2),    e.xb2);
    checkOutput("en_block1", int'(o_en_block1),  e.en1);
    checkOutput("en_block2", int'(o_en_block2),  e.en2);
    checkOutput("type_block1", int'(o_type_block1), e.tb1);
    checkOutput("type_block2", int'(o_type_block2), e.tb2);
    checkOutput("x_man",    int'(o_x_man),       e.xman);
    checkOutput("y_man",    int'(o_y_man),       e.yman);
    checkOutput("squeeze",  int'(o_squeeze_man), e.sq);
    checkOutput("score",    int'(o_score),       e.score);
  endtask

  // One tick with the given button level followed by a quiet cycle with
  // the button held, so a non-tick cycle must leave the outputs alone.
  task automatic applyStimulus(input bit btn, input bit chk);
    sb_entry_t ent;
    @(negedge clk);
    rst    = 1'b0;
    i_tick = 1'b1;
    i_btn  = btn;
    ent.chk = chk;
    ent.e   = exp_cur;
    sb_q.push_back(ent);
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  task automatic applyReset(input bit tick);
    sb_entry_t ent;
    @(negedge clk);
    rst    = 1'b1;
    i_tick = tick;
    i_btn  = 1'b0;
    exp_cur = reset_snap();
    ent.chk = 1'b1;
    ent.e   = exp_cur;
    sb_q.push_back(ent);
    @(negedge clk);
    rst    = 1'b0;
    i_tick = 1'b0;
  endtask

  task automatic holdPhase(input int n);
    for (int i = 1; i <= n; i++) begin
      exp_cur.sq = (i / 4 > 15) ? 15 : i / 4;
      applyStimulus(1'b1, 1'b1);
    end
  endtask

  // outcome: 0 = land on block2, 1 = land on block1, 2 = game over
  task automatic jumpPhase(input int d, input int x0, input int outcome);
    int steps;
    steps = (d == 0) ? 1 : d;
    for (int k = 1; k <= steps; k++) begin
      if (d != 0) begin
        exp_cur.xman = x0 + k;
        exp_cur.yman = (k <= d / 2) ? k : d - k;
      end
      if (k == steps) begin
        exp_cur.yman = 0;
        case (outcome)
          0: begin
            exp_cur.score = exp_cur.score + 1;
            exp_cur.en1   = 0;
          end
          2: exp_cur.gameover = 1;
          default: begin
          end
        endcase
      end
      applyStimulus(1'b0, 1'b1);
    end
  endtask

  // Monitor: every edge that saw a tick or reset is an output update.
  initial begin
    sb_entry_t ent;
    forever begin
      @(posedge clk);
      if (i_tick || rst) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty: got update with no expectation queued");
        end else begin
          ent = sb_q.pop_front();
          if (ent.chk) compareSnap(ent.e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    i_tick = 1'b0;
    i_btn  = 1'b0;
    exp_cur = reset_snap();

    $display("[TB] reset and title screen");
    applyReset(1'b0);
    applyStimulus(1'b0, 1'b1);
    exp_cur.title = 0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] charge 28 ticks, jump 14, land on block2, scroll");
    applyStimulus(1'b1, 1'b1);
    holdPhase(28);
    exp_cur.sq = 0;
    applyStimulus(1'b0, 1'b1);
    jumpPhase(14, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      exp_cur.xb2  = 15 - k;
      exp_cur.xman = (14 - k > 0) ? 14 - k : 0;
      if (k == 15) begin
        exp_cur.xb1 = 0;
        exp_cur.tb1 = 0;
        exp_cur.en1 = 1;
        exp_cur.xb2 = 12;
        exp_cur.tb2 = 1;
        exp_cur.en2 = 1;
      end
      applyStimulus((k < 15) ? bit'(k % 2) : 1'b0, 1'b1);
    end

    $display("[TB] charge 8 ticks, short jump, game over, restart");
    applyStimulus(1'b1, 1'b1);
    holdPhase(8);
    exp_cur.sq = 0;
    applyStimulus(1'b0, 1'b1);
    jumpPhase(4, 0, 2);
    applyStimulus(1'b0, 1'b1);
    exp_cur = reset_snap();
    exp_cur.title = 0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] zero-distance jump and block1 landing");
    applyStimulus(1'b1, 1'b1);
    holdPhase(1);
    exp_cur.sq = 0;
    applyStimulus(1'b0, 1'b1);
    jumpPhase(0, 0, 1);
    applyStimulus(1'b1, 1'b1);
    holdPhase(4);
    exp_cur.sq = 0;
    applyStimulus(1'b0, 1'b1);
    jumpPhase(2, 0, 1);

    $display("[TB] squeeze saturation and long jump");
    applyStimulus(1'b1, 1'b1);
    holdPhase(70);
    exp_cur.sq = 0;
    applyStimulus(1'b0, 1'b1);
    jumpPhase(30, 2, 2);
    exp_cur = reset_snap();
    exp_cur.title = 0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] reset during jump");
    applyStimulus(1'b1, 1'b1);
    holdPhase(12);
    exp_cur.sq = 0;
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      exp_cur.xman = k;
      exp_cur.yman = (k <= 3) ? k : 6 - k;
      applyStimulus(1'b0, 1'b1);
    end
    applyReset(1'b1);
    applyStimulus(1'b0, 1'b1);
    exp_cur.title = 0;
    applyStimulus(1'b1, 1'b1);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Jump-game controller that sits directly upstream of `graphics`. Once per frame tick it samples the player button and runs the game state machine: title, charge, jump, landing check, scroll, game over. It drives every scene input that `graphics` consumes: block positions, block types and enables, man position, squeeze level, and the title/game-over flags. It also keeps a running score.

## Interface
Parameters:
- `CHARGE_TICKS`, 4: ticks of held button per squeeze increment.
- `JUMP_STEP`, 2: jump distance units per squeeze level.
- `GAP_MIN`, 8: minimum x of a newly spawned block2.
- `X_INIT2`, 15: block2 x after reset or restart.
- `SEED`, 8'hA5: LFSR seed; nonzero.

Ports:
- `clk` in 1: system clock, the same domain as `graphics`.
- `rst` in 1: synchronous, active-high reset.
- `i_tick` in 1: one-cycle frame pulse; all game state advances only on tick cycles.
- `i_btn` in 1: debounced button level.
- `o_x_block1`, `o_x_block2` out 10: block x positions.
- `o_en_block1`, `o_en_block2` out 1: block visible.
- `o_type_block1`, `o_type_block2` out 4: block type.
- `o_x_man`, `o_y_man` out 10: man x; man height above block surface.
- `o_squeeze_man` out 4: charge level, 0..15.
- `o_title`, `o_gameover` out 1: screen flags.
- `o_score` out 8: successful landings, saturating at 255.

## Operation
- `press` = `i_btn` & ~`btn_q`. `btn_q` is `i_btn` registered on tick cycles only.
- Half-width: `hw(t)` = 2 + `t[1:0]`.
- **TITLE** (`o_title`=1): `press` → IDLE.
- **IDLE**: `press` → CHARGE.
- **CHARGE**:
  - Each tick with `i_btn`=1 advances a tick counter; every `CHARGE_TICKS` ticks, squeeze += 1, saturating at 15.
  - A tick with `i_btn`=0 → JUMP with D = squeeze*`JUMP_STEP`; squeeze clears to 0.
  - If release and an increment fall on the same tick, release wins and the increment is dropped.
- **JUMP**, counter j = 0..D-1, each tick:
  - x_man += 1.
  - y_man += 1 if j < D/2, else y_man -= 1, floored at 0.
  - After the last step, evaluate the landing (below).
  - D=0: evaluate the landing on the first tick, with no motion.
- **Landing**, with y_man forced to 0:
  - |x_man − x_block2| ≤ hw(type_block2) → score += 1, go to SCROLL.
  - Else |x_man − x_block1| ≤ hw(type_block1) → IDLE, no score.
  - Else → GAMEOVER.
- **SCROLL**: `o_en_block1`=0.
  - Each tick while x_block2 > 0: x_block2 −= 1 and x_man −= 1, x_man clamped at 0.
  - When x_block2 = 0:
    - block1 takes x=0 and type_block2; `o_en_block1`=1.
    - block2 ← spawner (x, type); `o_en_block2`=1.
    - → IDLE.
- **GAMEOVER** (`o_gameover`=1): `press` → restore reset field values except `o_title`=0, score=0 → IDLE.
- All differences are computed as 10-bit unsigned absolute values.

## Timing
- All outputs are registered. They update on the clk edge that samples `i_tick`=1, so latency is 1 clk after the tick.
- Reset state: TITLE; `o_title`=1, `o_gameover`=0. Blocks: `o_x_block1`=0, `o_x_block2`=`X_INIT2`, both enables=1, both types=0. Man and scoring: `o_x_man`=`o_y_man`=0, `o_squeeze_man`=0, `o_score`=0. Internal: `btn_q`=0, LFSR=`SEED`, all counters 0.
- `rst` wins over `i_tick`. Reset in any state, including mid-JUMP or mid-SCROLL, returns to the reset state on the next edge.
- A `press` during JUMP or SCROLL is ignored, though `btn_q` still tracks `i_btn`.

## Configuration
- `GAME_RANDOM_EN` defined:
  - 8-bit Fibonacci LFSR with taps 8,6,5,4, stepped once per spawn.
  - New x = `GAP_MIN` + lfsr[3:0]; new type = {2'b00, lfsr[5:4]}.
- Undefined:
  - Deterministic 4-entry cycle, index reset to 0.
  - Gap offsets 4, 8, 2, 6; types 1, 2, 0, 3.

## Structure
- Package `game_pkg`:
  - state enum (TITLE, IDLE, CHARGE, JUMP, SCROLL, GAMEOVER);
  - `hw()` function;
  - deterministic gap/type tables;
  - LFSR tap constant.
- Sub-module `block_spawner`:
  - inputs `clk`/`rst`/`spawn`; outputs next x and type;
  - contains the `GAME_RANDOM_EN` selection.

## Test plan
All scenarios below use default parameters with `GAME_RANDOM_EN` undefined.
- Reset, then press → `o_title` 1→0 one clk after the tick; state IDLE.
- Hold 28 ticks, release → squeeze reaches 7; 14 jump ticks; x_man=14, y_man peaks at 7 → score=1. Then 15 scroll ticks → block1 x=0 type=0; block2 x=12 type=1, both enabled.
- Hold 8 ticks, release → D=4, x_man=4 → `o_gameover`=1; next press → field restored, score=0, IDLE.
- Press and release after 1 tick → D=0 → IDLE, x_man=0, score unchanged. Hold 4 ticks → D=2, x_man=2 lands on block1 → IDLE, no score.
- Hold 70 ticks → squeeze saturates at 15; release → D=30 → GAMEOVER.
- Assert `rst` on jump tick 5 → all outputs return to reset values on the next edge.
